// File: rtl/seq_det_101_pkg.sv
// Shared state encoding for the "101" Moore sequence detector.
package seq_det_101_pkg;

   localparam int unsigned STATE_W = 2;

   typedef logic [STATE_W-1:0] state_t;

   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_1    = 2'd1;
   localparam state_t S_10   = 2'd2;
   localparam state_t S_DET  = 2'd3;

endpackage

// File: rtl/seq_det_101_moore.sv
// Moore FSM detecting serial "101"; y is decoded from the state register only.
// Optional saturating detection counter on det_cnt when SEQ_DET_101_CNT_EN is defined.
module seq_det_101_moore
   import seq_det_101_pkg::*;
#(
   parameter int unsigned OVERLAP = 1,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             x,
`ifdef SEQ_DET_101_CNT_EN
   output logic [CNT_W-1:0] det_cnt,
`endif
   output logic             y
);

   state_t state_q, state_d;

   always_comb begin
      state_d = S_IDLE;
      case (state_q)
         S_IDLE:  state_d = x ? S_1 : S_IDLE;
         S_1:     state_d = x ? S_1 : S_10;
         S_10:    state_d = x ? S_DET : S_IDLE;
         // The trailing "1" of a match always seeds S_1; only x=0 depends on overlap.
         S_DET:   state_d = x ? S_1 : ((OVERLAP != 0) ? S_10 : S_IDLE);
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign y = (state_q == S_DET);

`ifdef SEQ_DET_101_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if ((state_d == S_DET) && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign det_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_det_101_moore.sv
// Bench for seq_det_101_moore: overlapping and non-overlapping instances share stimulus.
module tb_seq_det_101_moore;

   logic clk;
   logic rst;
   logic x;
   logic y_ov;
   logic y_nov;
`ifdef SEQ_DET_101_CNT_EN
   logic [1:0] cnt_ov;
   logic [1:0] cnt_nov;
`endif

   int n_cmp;
   int n_fail;

   logic q_ov[$];
   logic q_nov[$];
`ifdef SEQ_DET_101_CNT_EN
   logic [1:0] q_cnt[$];
`endif

   seq_det_101_moore #(
      .OVERLAP(1),
      .CNT_W  (2)
   ) u_dut_ov (
      .clk    (clk),
      .rst    (rst),
      .x      (x),
`ifdef SEQ_DET_101_CNT_EN
      .det_cnt(cnt_ov),
`endif
      .y      (y_ov)
   );

   seq_det_101_moore #(
      .OVERLAP(0),
      .CNT_W  (2)
   ) u_dut_nov (
      .clk    (clk),
      .rst    (rst),
      .x      (x),
`ifdef SEQ_DET_101_CNT_EN
      .det_cnt(cnt_nov),
`endif
      .y      (y_nov)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one bit, queue the expected flags, and return 1 time unit after the edge.
   task automatic drive_bit(input logic xv, input logic rv, input logic e_ov, input logic e_nov);
      x   = xv;
      rst = rv;
      q_ov.push_back(e_ov);
      q_nov.push_back(e_nov);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic e;
      drive_bit(1'b0, 1'b1, 1'b0, 1'b0);
      e = q_ov.pop_front();
      n_cmp++;
      if (y_ov !== e) begin
         n_fail++;
         $display("FAIL reset_ov: y=%b expected %b", y_ov, e);
      end
      e = q_nov.pop_front();
      n_cmp++;
      if (y_nov !== e) begin
         n_fail++;
         $display("FAIL reset_nov: y=%b expected %b", y_nov, e);
      end
`ifdef SEQ_DET_101_CNT_EN
      n_cmp++;
      if (cnt_ov !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_cnt: det_cnt=%0d expected 0", cnt_ov);
      end
`endif
   endtask

   task automatic test_basic();
      logic xs[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic es[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic e;
      drive_bit(1'b0, 1'b1, 1'b0, 1'b0);
      void'(q_ov.pop_front());
      void'(q_nov.pop_front());
      for (int i = 0; i < 4; i++) begin
         drive_bit(xs[i], 1'b0, es[i], es[i]);
         e = q_ov.pop_front();
         n_cmp++;
         if (y_ov !== e) begin
            n_fail++;
            $display("FAIL basic_ov bit %0d: y=%b expected %b", i + 1, y_ov, e);
         end
         e = q_nov.pop_front();
         n_cmp++;
         if (y_nov !== e) begin
            n_fail++;
            $display("FAIL basic_nov bit %0d: y=%b expected %b", i + 1, y_nov, e);
         end
      end
   endtask

   task automatic test_stream();
      logic xs[15] = '{0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1, 0, 0};
      // Pulses after bits 6, 11, 13 (overlap) and 6, 11 (no overlap).
      logic eo[15] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0};
      logic en[15] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
      logic e;
      int   pulses;
      pulses = 0;
      drive_bit(1'b0, 1'b1, 1'b0, 1'b0);
      void'(q_ov.pop_front());
      void'(q_nov.pop_front());
      for (int i = 0; i < 15; i++) begin
         drive_bit(xs[i], 1'b0, eo[i], en[i]);
         if (y_ov === 1'b1) pulses++;
         e = q_ov.pop_front();
         n_cmp++;
         if (y_ov !== e) begin
            n_fail++;
            $display("FAIL stream_ov bit %0d: y=%b expected %b", i + 1, y_ov, e);
         end
         e = q_nov.pop_front();
         n_cmp++;
         if (y_nov !== e) begin
            n_fail++;
            $display("FAIL stream_nov bit %0d: y=%b expected %b", i + 1, y_nov, e);
         end
      end
      n_cmp++;
      if (pulses != 3) begin
         n_fail++;
         $display("FAIL stream_pulse_count: got %0d expected 3", pulses);
      end
   endtask

   task automatic test_overlap();
      logic xs[5] = '{1, 0, 1, 0, 1};
      logic eo[5] = '{0, 0, 1, 0, 1};
      logic en[5] = '{0, 0, 1, 0, 0};
      logic e;
      drive_bit(1'b0, 1'b1, 1'b0, 1'b0);
      void'(q_ov.pop_front());
      void'(q_nov.pop_front());
      for (int i = 0; i < 5; i++) begin
         drive_bit(xs[i], 1'b0, eo[i], en[i]);
         e = q_ov.pop_front();
         n_cmp++;
         if (y_ov !== e) begin
            n_fail++;
            $display("FAIL overlap_ov bit %0d: y=%b expected %b", i + 1, y_ov, e);
         end
         e = q_nov.pop_front();
         n_cmp++;
         if (y_nov !== e) begin
            n_fail++;
            $display("FAIL overlap_nov bit %0d: y=%b expected %b", i + 1, y_nov, e);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic xs[8] = '{1, 0, 1, 0, 1, 1, 0, 1};
      logic rs[8] = '{0, 0, 1, 0, 0, 0, 0, 0};
      logic es[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
      logic e;
      drive_bit(1'b0, 1'b1, 1'b0, 1'b0);
      void'(q_ov.pop_front());
      void'(q_nov.pop_front());
      for (int i = 0; i < 8; i++) begin
         drive_bit(xs[i], rs[i], es[i], es[i]);
         e = q_ov.pop_front();
         n_cmp++;
         if (y_ov !== e) begin
            n_fail++;
            $display("FAIL reset_mid_ov step %0d: y=%b expected %b", i + 1, y_ov, e);
         end
         e = q_nov.pop_front();
         n_cmp++;
         if (y_nov !== e) begin
            n_fail++;
            $display("FAIL reset_mid_nov step %0d: y=%b expected %b", i + 1, y_nov, e);
         end
      end
   endtask

   task automatic test_runs();
      // Trailing 0,1 proves the run left the FSM in S_1.
      logic xs[9] = '{1, 1, 1, 1, 0, 0, 1, 0, 1};
      logic es[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
      logic e;
      drive_bit(1'b0, 1'b1, 1'b0, 1'b0);
      void'(q_ov.pop_front());
      void'(q_nov.pop_front());
      for (int i = 0; i < 9; i++) begin
         drive_bit(xs[i], 1'b0, es[i], es[i]);
         e = q_ov.pop_front();
         n_cmp++;
         if (y_ov !== e) begin
            n_fail++;
            $display("FAIL runs_ov bit %0d: y=%b expected %b", i + 1, y_ov, e);
         end
         e = q_nov.pop_front();
         n_cmp++;
         if (y_nov !== e) begin
            n_fail++;
            $display("FAIL runs_nov bit %0d: y=%b expected %b", i + 1, y_nov, e);
         end
      end
   endtask

`ifdef SEQ_DET_101_CNT_EN
   task automatic test_counter();
      logic       xs[11] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
      logic [1:0] cs[11] = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 3, 3};
      logic [1:0] c;
      drive_bit(1'b0, 1'b1, 1'b0, 1'b0);
      void'(q_ov.pop_front());
      void'(q_nov.pop_front());
      for (int i = 0; i < 11; i++) begin
         q_cnt.push_back(cs[i]);
         drive_bit(xs[i], 1'b0, 1'b0, 1'b0);
         void'(q_ov.pop_front());
         void'(q_nov.pop_front());
         c = q_cnt.pop_front();
         n_cmp++;
         if (cnt_ov !== c) begin
            n_fail++;
            $display("FAIL counter bit %0d: det_cnt=%0d expected %0d", i + 1, cnt_ov, c);
         end
      end
      drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
      void'(q_ov.pop_front());
      void'(q_nov.pop_front());
      n_cmp++;
      if (cnt_ov !== 2'd0) begin
         n_fail++;
         $display("FAIL counter_clear: det_cnt=%0d expected 0", cnt_ov);
      end
   endtask
`endif

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      x      = 1'b0;
      rst    = 1'b0;
      test_reset();
      test_basic();
      test_stream();
      test_overlap();
      test_reset_mid();
      test_runs();
`ifdef SEQ_DET_101_CNT_EN
      test_counter();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_det_101_moore.md
Name: seq_det_101_moore

Overview:
- Moore finite-state machine that detects the serial bit pattern "101" on a 1-bit input stream, sampling one bit per clock.
- Asserts a registered detect flag for one cycle after each match.
- Leaf block for serial-protocol front ends; output depends only on the current state.
- Overlapping detection is the default; non-overlapping is selectable by parameter.

Parameters:
- OVERLAP, 1, 1 = the final "1" of a match may start the next match (overlapping); 0 = the search restarts after a match.
- CNT_W, 8, width of the optional saturating detection counter (legal range 1..32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high; sampled on the rising edge of clk.
- x  input  1  serial data bit, sampled on every rising edge of clk.
- y  output  1  detect flag, high only in state S_DET.
- det_cnt  output  CNT_W  number of detections seen; present only when SEQ_DET_101_CNT_EN is defined.

Behaviour:
- One clock domain. Reset is synchronous and active-high: if rst=1 at a rising edge, state <= S_IDLE, y=0 and det_cnt=0. x is ignored in that cycle.
- State encoding is 2-bit binary, held in the shared package:
  - S_IDLE=0: nothing matched.
  - S_1=1: "1" seen.
  - S_10=2: "10" seen.
  - S_DET=3: "101" seen.
- Transitions, applied on each rising edge when rst=0:
  - S_IDLE: x=1 -> S_1; x=0 -> S_IDLE.
  - S_1: x=0 -> S_10; x=1 -> S_1 (a run of 1s stays in S_1).
  - S_10: x=1 -> S_DET; x=0 -> S_IDLE.
  - S_DET, OVERLAP=1: x=0 -> S_10; x=1 -> S_1.
  - S_DET, OVERLAP=0: x=0 -> S_IDLE; x=1 -> S_1.
- Output: y = (state == S_DET). y is decoded directly from the state register with no input term (pure Moore).
- Latency: y rises in the clock cycle that follows the edge sampling the third bit of a match. It stays high for exactly one cycle unless the next match completes immediately; under OVERLAP, the pattern "10101" yields two pulses separated by one low cycle.
- y is glitch-free: it is decoded from flops only.
- Before the first reset, state is unknown (X). The bench must apply rst before checking y.
- Reset mid-pattern discards any partial match. The next match needs a full "101" after rst is released.
- Illegal or unreachable states: none exist with a 2-bit encoding. The default branch of the next-state logic goes to S_IDLE.

Optional Feature:
- Macro: SEQ_DET_101_CNT_EN.
- When defined:
  - Port det_cnt is added.
  - The counter increments on each rising edge at which the next state is S_DET (rst=0).
  - It saturates at 2^CNT_W-1; it never wraps.
  - It clears on rst.
- When undefined: no det_cnt port and no counter logic. Behaviour of y is identical in both builds.

Decomposition:
- Package seq_det_101_pkg holds the state typedef/localparams (S_IDLE, S_1, S_10, S_DET) and the state width constant (2).
- No sub-module is needed: one next-state combinational block, one state register, one output decode, and the optional counter, all in one module.

Test Plan:
- Reset then x=1,0,1 on three consecutive edges -> y=0 throughout the pattern, y=1 for exactly one cycle after the third edge, then y=0 on x=0.
- Stream 0,1,1,1,0,1,0,0,1,0,1,0,1,0,0 after reset (OVERLAP=1) -> y pulses after the 6th, 11th and 13th bits; 3 pulses in total, none elsewhere.
- Overlap check, OVERLAP=1, x=1,0,1,0,1 -> two y pulses (after bits 3 and 5). With OVERLAP=0 the same stream -> one pulse (after bit 3).
- Reset mid-pattern: x=1,0, then rst=1 for one cycle with x=1, then rst=0 and x=0,1 -> no y pulse. A fresh 1,0,1 then pulses y.
- Run of ones and zeros: x=1,1,1,1,0,0,1 -> y never asserts; state ends in S_1.
- With SEQ_DET_101_CNT_EN and CNT_W=2: repeat "10" pattern with overlap to produce 5 matches -> det_cnt reads 1,2,3,3,3 (saturates); rst -> det_cnt=0.
